// File: rtl/sub_32bit_serial_pkg.sv
// Shared constants, state encoding and parameter checks for the serial subtractor.
package sub_32bit_serial_pkg;

    localparam int unsigned WordW = 32;
    localparam int unsigned IdxW  = $clog2(WordW);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Slice width must divide the word into a power-of-two number of slices.
    function automatic bit slice_w_legal(input int unsigned slice_w);
        return (slice_w == 1) || (slice_w == 2) || (slice_w == 4) ||
               (slice_w == 8) || (slice_w == 16) || (slice_w == 32);
    endfunction

    // Slice counter width: log2(slice count), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned slice_w);
        int unsigned n;
        n = WordW / slice_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_32bit_serial_if.sv
// Request/response bundle between a requester and the serial subtractor.
interface sub_32bit_serial_if
    import sub_32bit_serial_pkg::*;
();
    logic             start;
    logic [WordW-1:0] x;
    logic [WordW-1:0] y;
    logic             b_in;
    logic [WordW-1:0] z;
    logic             b_out;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output start, x, y, b_in,
        input  z, b_out, v, busy, done
    );

    modport slave (
        input  start, x, y, b_in,
        output z, b_out, v, busy, done
    );
endinterface

// File: rtl/sub_32bit_serial_sub_slice.sv
// Combinational WIDTH-bit subtract with borrow-in and borrow-out.
module sub_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);
    localparam int unsigned ExtW = WIDTH + 1;

    logic [ExtW-1:0] ext;

    // Zero-extended difference; the extra top bit goes high exactly when a < b + b_in.
    always_comb begin
        ext   = {1'b0, a} - {1'b0, b} - ExtW'(b_in);
        d     = ext[WIDTH-1:0];
        b_out = ext[WIDTH];
    end
endmodule

// File: rtl/sub_32bit_serial.sv
// Multi-cycle 32-bit subtractor: one SLICE_W-bit slice per clock through a single slice unit.
module sub_32bit_serial
    import sub_32bit_serial_pkg::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    sub_32bit_serial_if.slave   bus
);
    localparam int unsigned  NSlice = WordW / SLICE_W;
    localparam int unsigned  CntW   = cnt_width(SLICE_W);
    localparam logic [CntW-1:0] LastK = CntW'(NSlice - 1);

    if (!slice_w_legal(SLICE_W)) begin : g_bad_slice_w
        $error("SLICE_W must be one of 1, 2, 4, 8, 16, 32");
    end

    state_e           state_q, state_d;
    logic             busy, done;

    logic [WordW-1:0] x_q, y_q, diff_q, diff_d, z_q;
    logic             borrow_q, b_out_q, v_q;
    logic [CntW-1:0]  k_q;
    logic [IdxW-1:0]  base_idx;

    logic [SLICE_W-1:0] x_slice, y_slice, slice_d;
    logic               slice_bout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; START only matters in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (k_q == LastK) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StRun:   busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Select the current slice of both operands.
    always_comb begin
        base_idx = IdxW'(k_q * SLICE_W);
        x_slice  = x_q[base_idx +: SLICE_W];
        y_slice  = y_q[base_idx +: SLICE_W];
    end

    sub_slice #(
        .WIDTH (SLICE_W)
    ) u_slice (
        .a     (x_slice),
        .b     (y_slice),
        .b_in  (borrow_q),
        .d     (slice_d),
        .b_out (slice_bout)
    );

    // Partial difference with the current slice merged in; the full word on the last slice.
    always_comb begin
        diff_d = diff_q;
        diff_d[base_idx +: SLICE_W] = slice_d;
    end

    // Operand capture, per-slice accumulation and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            z_q      <= '0;
            b_out_q  <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        x_q      <= bus.x;
                        y_q      <= bus.y;
                        borrow_q <= bus.b_in;
                        diff_q   <= '0;
                        k_q      <= '0;
                    end
                end
                StRun: begin
                    diff_q   <= diff_d;
                    borrow_q <= slice_bout;
                    k_q      <= k_q + CntW'(1);
                    if (k_q == LastK) begin
                        z_q     <= diff_d;
                        b_out_q <= slice_bout;
                        // Signed overflow: operand signs differ and result sign left the minuend's.
                        v_q     <= (x_q[WordW-1] ^ y_q[WordW-1]) &
                                   (diff_d[WordW-1] ^ x_q[WordW-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.z     = z_q;
    assign bus.b_out = b_out_q;
    assign bus.v     = v_q;
    assign bus.busy  = busy;
    assign bus.done  = done;

endmodule
